// File: rtl/alu_5bit_if.sv
// ----------------------------------------------------------------------------
// alu_5bit_if: operand/opcode/result bundle for the 5-bit registered ALU.
//   a  [4:0]  operand A (unsigned)
//   b  [4:0]  operand B (unsigned)
//   s  [3:0]  opcode
//   y  [4:0]  registered result
//   c         registered carry/borrow/shift-out flag
//   z         registered zero flag
// master drives a/b/s and observes y/c/z; slave is the ALU side.
// ----------------------------------------------------------------------------
interface alu_5bit_if;
    localparam int unsigned DATA_W = 5;
    localparam int unsigned OP_W   = 4;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   s;
    logic [DATA_W-1:0] y;
    logic              c;
    logic              z;

    modport master (output a, output b, output s, input  y, input  c, input  z);
    modport slave  (input  a, input  b, input  s, output y, output c, output z);
endinterface

// File: rtl/alu_5bit.sv
// ----------------------------------------------------------------------------
// alu_5bit: 5-bit ALU with 16 opcodes; result and carry/zero flags are
// registered once per clock (latency 1, new result every cycle).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (y=0, c=0, z=0 while low)
//   bus    alu_5bit_if.slave: a, b, s in; y, c, z out
// Configuration:
//   ALU5_SAT_EN  when defined, ADD/INC clamp to 5'h1F on carry and SUB clamps
//                to 5'h00 on borrow; c still reports the raw carry/borrow.
// ----------------------------------------------------------------------------
module alu_5bit (
    input  logic       clk,
    input  logic       rst_n,
    alu_5bit_if.slave  bus
);
    localparam int unsigned W = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
        OP_XOR  = 4'h4, OP_XNOR = 4'h5, OP_NOTA = 4'h6, OP_NOTB = 4'h7,
        OP_NAND = 4'h8, OP_NOR  = 4'h9, OP_SHL  = 4'hA, OP_SHR  = 4'hB,
        OP_SLT  = 4'hC, OP_PASB = 4'hD, OP_INC  = 4'hE, OP_MAX  = 4'hF
    } op_e;

    logic [W:0]   sum_c;
    logic [W:0]   diff_c;
    logic [W:0]   inc_c;
    logic [W-1:0] y_nxt_c;
    logic         c_nxt_c;

    // Extended-width arithmetic: the top bit is the raw carry (or borrow for SUB).
    always_comb begin
        sum_c  = {1'b0, bus.a} + {1'b0, bus.b};
        diff_c = {1'b0, bus.a} - {1'b0, bus.b};
        inc_c  = {1'b0, bus.a} + (W+1)'(1);
    end

    // Next result and flag selection.
    always_comb begin
        y_nxt_c = '0;
        c_nxt_c = 1'b0;
        unique case (op_e'(bus.s))
            OP_ADD: begin
                c_nxt_c = sum_c[W];
`ifdef ALU5_SAT_EN
                y_nxt_c = sum_c[W] ? {W{1'b1}} : sum_c[W-1:0];
`else
                y_nxt_c = sum_c[W-1:0];
`endif
            end
            OP_SUB: begin
                c_nxt_c = diff_c[W];
`ifdef ALU5_SAT_EN
                y_nxt_c = diff_c[W] ? '0 : diff_c[W-1:0];
`else
                y_nxt_c = diff_c[W-1:0];
`endif
            end
            OP_AND:  y_nxt_c = bus.a & bus.b;
            OP_OR:   y_nxt_c = bus.a | bus.b;
            OP_XOR:  y_nxt_c = bus.a ^ bus.b;
            OP_XNOR: y_nxt_c = ~(bus.a ^ bus.b);
            OP_NOTA: y_nxt_c = ~bus.a;
            OP_NOTB: y_nxt_c = ~bus.b;
            OP_NAND: y_nxt_c = ~(bus.a & bus.b);
            OP_NOR:  y_nxt_c = ~(bus.a | bus.b);
            OP_SHL: begin
                y_nxt_c = {bus.a[W-2:0], 1'b0};
                c_nxt_c = bus.a[W-1];
            end
            OP_SHR: begin
                y_nxt_c = {1'b0, bus.a[W-1:1]};
                c_nxt_c = bus.a[0];
            end
            OP_SLT:  y_nxt_c = W'(bus.a < bus.b);
            OP_PASB: y_nxt_c = bus.b;
            OP_INC: begin
                c_nxt_c = inc_c[W];
`ifdef ALU5_SAT_EN
                y_nxt_c = inc_c[W] ? {W{1'b1}} : inc_c[W-1:0];
`else
                y_nxt_c = inc_c[W-1:0];
`endif
            end
            OP_MAX:  y_nxt_c = (bus.a >= bus.b) ? bus.a : bus.b;
        endcase
    end

    // Output registers; z is taken from the final (post-saturation) result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.y <= '0;
            bus.c <= 1'b0;
            bus.z <= 1'b0;
        end else begin
            bus.y <= y_nxt_c;
            bus.c <= c_nxt_c;
            bus.z <= (y_nxt_c == '0);
        end
    end
endmodule

// File: tb/tb_alu_5bit.sv
// ----------------------------------------------------------------------------
// tb_alu_5bit: self-checking bench for alu_5bit. Directed vectors plus random
// operations are compared against an integer-arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_alu_5bit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    alu_5bit_if bus ();

    alu_5bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0] y;
        logic       c;
        logic       z;
    } res_t;

    typedef struct packed {
        logic [3:0] s;
        logic [4:0] a;
        logic [4:0] b;
    } vec_t;

    res_t prev_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input res_t exp);
        check($sformatf("%s.y", tag), 32'(bus.y), 32'(exp.y));
        check($sformatf("%s.c", tag), 32'(bus.c), 32'(exp.c));
        check($sformatf("%s.z", tag), 32'(bus.z), 32'(exp.z));
    endtask

    // Reference model: plain unsigned integer arithmetic on the opcode table.
    function automatic res_t model(input int op, input int a, input int b);
        int   y;
        int   cy;
        res_t r;
        y  = 0;
        cy = 0;
        case (op)
            0: begin
                cy = (a + b > 31) ? 1 : 0;
                y  = (a + b) % 32;
`ifdef ALU5_SAT_EN
                if (cy != 0) y = 31;
`endif
            end
            1: begin
                cy = (a < b) ? 1 : 0;
                y  = (a - b + 32) % 32;
`ifdef ALU5_SAT_EN
                if (cy != 0) y = 0;
`endif
            end
            2:  y = a & b;
            3:  y = a | b;
            4:  y = a ^ b;
            5:  y = 31 - (a ^ b);
            6:  y = 31 - a;
            7:  y = 31 - b;
            8:  y = 31 - (a & b);
            9:  y = 31 - (a | b);
            10: begin y = (a * 2) % 32; cy = a / 16; end
            11: begin y = a / 2;        cy = a % 2;  end
            12: y = (a < b) ? 1 : 0;
            13: y = b;
            14: begin
                cy = (a + 1 > 31) ? 1 : 0;
                y  = (a + 1) % 32;
`ifdef ALU5_SAT_EN
                if (cy != 0) y = 31;
`endif
            end
            default: y = (a >= b) ? a : b;
        endcase
        r.y = 5'(y);
        r.c = 1'(cy);
        r.z = (y == 0);
        return r;
    endfunction

    // Drive one op just after an edge, confirm the outputs still hold the
    // previous result, then check the new result one edge later.
    task automatic step(input int op, input int a, input int b);
        res_t exp;
        bus.s = 4'(op);
        bus.a = 5'(a);
        bus.b = 5'(b);
        #1;
        check_out($sformatf("hold s=%0h", op), prev_exp);
        @(posedge clk);
        #1;
        exp = model(op, a, b);
        check_out($sformatf("op s=%0h a=%0h b=%0h", op, a, b), exp);
        prev_exp = exp;
    endtask

    vec_t dir [$];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s = 4'h0;
        bus.a = 5'h07;
        bus.b = 5'h03;
        #1 rst_n = 1'b0;
        #1;
        check_out("reset_async", '0);
        @(posedge clk);
        #1;
        check_out("reset_held", '0);
        prev_exp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        prev_exp = model(0, 7, 3);
        check_out("first_after_reset", prev_exp);

        dir = '{
            '{4'h0, 5'h07, 5'h03}, '{4'h1, 5'h03, 5'h08}, '{4'hE, 5'h16, 5'h00},
            '{4'h2, 5'h15, 5'h13}, '{4'h3, 5'h01, 5'h0C}, '{4'h4, 5'h12, 5'h05},
            '{4'h5, 5'h0A, 5'h0A}, '{4'h6, 5'h0F, 5'h1F}, '{4'h7, 5'h11, 5'h04},
            '{4'h8, 5'h19, 5'h15}, '{4'h9, 5'h05, 5'h0C}, '{4'hA, 5'h06, 5'h1F},
            '{4'hB, 5'h09, 5'h00}, '{4'hC, 5'h19, 5'h0A}, '{4'hD, 5'h03, 5'h15},
            '{4'hF, 5'h12, 5'h0D}, '{4'h0, 5'h1F, 5'h01}, '{4'h1, 5'h00, 5'h01},
            '{4'hE, 5'h1F, 5'h09}, '{4'hA, 5'h10, 5'h00}, '{4'hC, 5'h02, 5'h03},
            '{4'hF, 5'h04, 5'h1C}, '{4'h1, 5'h05, 5'h05}
        };
        foreach (dir[i]) step(int'(dir[i].s), int'(dir[i].a), int'(dir[i].b));

        // Spot-check a few results against literal values, independent of the model.
        step(0, 7, 3);
        check("lit_add", 32'(bus.y), 32'h0A);
        step(4, 'h12, 'h05);
        check("lit_xor", 32'(bus.y), 32'h17);
        step(11, 'h09, 0);
        check("lit_shr_c", 32'(bus.c), 32'h1);

        // Reset asserted between edges clears outputs immediately.
        step(13, 0, 'h15);
        #2 rst_n = 1'b0;
        #1;
        check_out("reset_mid", '0);
        bus.s = 4'h3;
        bus.a = 5'h0F;
        bus.b = 5'h10;
        @(posedge clk);
        #1;
        check_out("reset_mid_held", '0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        prev_exp = model(3, 'h0F, 'h10);
        check_out("release_loads", prev_exp);

        // Random ops, opcode changes every cycle; bias operands toward edges.
        for (int n = 0; n < 400; n++) begin
            int op;
            int a;
            int b;
            op = int'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 31)
                                             : int'($urandom_range(0, 31));
            b  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 1 : 31)
                                             : int'($urandom_range(0, 31));
            step(op, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
